// File: rtl/vram_shadow.sv
// Shadow copy of the screen banks (5 and 7) fed by snooped Z80 writes, serving video fetches.
// Optional power-up clear of the shadow RAM is enabled with `define VRAM_CLEAR_EN.
module vram_shadow #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LVL_W      = 3
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [15:0]      addr,
  input  logic [7:0]       din,
  input  logic             nMREQ,
  input  logic             nWR,
  input  logic             m128,
  input  logic [2:0]       page_ram,
  input  logic             vid_page,
  input  logic             vram_rd,
  input  logic [12:0]      vram_addr,
  output logic [7:0]       vram_dout,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned OFF_W     = 13;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned RAM_AW    = OFF_W + 1;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam int unsigned ENTRY_W   = RAM_AW + DATA_W;

  logic               wr_act_c;
  logic               wr_q;
  logic               wr_edge_c;
  logic               hit5_c;
  logic               hit7_c;
  logic               capture_c;
  logic               full_c;
  logic               empty_c;
  logic               push_c;
  logic               pop_c;
  logic               run_c;
  logic [ENTRY_W-1:0] entry_c;
  logic [ENTRY_W-1:0] head_c;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ovf_q, ovf_d;
  logic [DATA_W-1:0]  dout_q, dout_d;

  logic [DATA_W-1:0]  ram_mem [RAM_DEPTH];
  logic               ram_we_c;
  logic [RAM_AW-1:0]  ram_waddr_c;
  logic [DATA_W-1:0]  ram_wdata_c;
  logic [RAM_AW-1:0]  ram_raddr_c;

  // One capture per CPU write: rising edge of the combined strobe
  assign wr_act_c  = ~nMREQ & ~nWR;
  assign wr_edge_c = wr_act_c & ~wr_q;

  assign hit5_c    = ~addr[13] & ((addr[15:14] == 2'b01) |
                     ((addr[15:14] == 2'b11) & m128 & (page_ram == 3'd5)));
  assign hit7_c    = ~addr[13] & (addr[15:14] == 2'b11) & m128 & (page_ram == 3'd7);
  assign capture_c = wr_edge_c & (hit5_c | hit7_c);
  assign entry_c   = {hit7_c, addr[OFF_W-1:0], din};

  assign full_c  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty_c = (level_q == '0);
  assign push_c  = capture_c & ~full_c;
  assign pop_c   = ~vram_rd & ~empty_c & run_c;
  assign head_c  = fifo_mem[rd_ptr_q];

  assign ram_raddr_c = {vid_page, vram_addr};

`ifdef VRAM_CLEAR_EN
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Walk every RAM address once, then hand the port to the FIFO
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + RAM_AW'(1);
        if (clr_cnt_q == RAM_AW'(RAM_DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign busy  = (state_q == ST_CLEAR);
  assign run_c = ~busy;
`else
  assign busy  = 1'b0;
  assign run_c = 1'b1;
`endif

  // RAM write port: clear sweep, else FIFO head; never on a reset clock
  always_comb begin
    ram_we_c    = pop_c;
    ram_waddr_c = head_c[ENTRY_W-1 -: RAM_AW];
    ram_wdata_c = head_c[DATA_W-1:0];
`ifdef VRAM_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      ram_we_c    = 1'b1;
      ram_waddr_c = clr_cnt_q;
      ram_wdata_c = '0;
    end
`endif
    if (reset) begin
      ram_we_c = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q | (capture_c & full_c);
    dout_d   = dout_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // Reads during the clear sweep return zero without touching the RAM
    if (vram_rd) begin
      dout_d = busy ? '0 : ram_mem[ram_raddr_c];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_q     <= wr_act_c;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_c) begin
      fifo_mem[wr_ptr_q] <= entry_c;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (ram_we_c) begin
      ram_mem[ram_waddr_c] <= ram_wdata_c;
    end
  end

  assign vram_dout  = dout_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_vram_shadow.sv
// Bench for vram_shadow: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue/array model of the shadow RAM and write FIFO.
module tb_vram_shadow;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LVL_W  = 3;
  localparam int          NBYTES = 16384;
`ifdef VRAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic             clk_sys = 1'b0;
  logic             reset = 1'b1;
  logic [15:0]      addr = '0;
  logic [7:0]       din = '0;
  logic             nMREQ = 1'b1;
  logic             nWR = 1'b1;
  logic             m128 = 1'b0;
  logic [2:0]       page_ram = '0;
  logic             vid_page = 1'b0;
  logic             vram_rd = 1'b0;
  logic [12:0]      vram_addr = '0;
  logic [7:0]       vram_dout;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             busy;

  always #5 clk_sys = ~clk_sys;

  vram_shadow #(.FIFO_DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .addr(addr), .din(din), .nMREQ(nMREQ), .nWR(nWR),
    .m128(m128), .page_ram(page_ram), .vid_page(vid_page), .vram_rd(vram_rd),
    .vram_addr(vram_addr), .vram_dout(vram_dout), .fifo_level(fifo_level),
    .overflow(overflow), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Screen bank a CPU write lands in, or -1 if it is not a screen write
  function automatic int bank_of(input logic [15:0] a, input logic m, input logic [2:0] p);
    if (a[13]) return -1;
    if (a[15:14] == 2'b01) return 5;
    if (a[15:14] == 2'b11 && m && p == 3'd5) return 5;
    if (a[15:14] == 2'b11 && m && p == 3'd7) return 7;
    return -1;
  endfunction

  bit   [7:0]  m_ram [NBYTES];
  bit          m_known [NBYTES];
  logic [21:0] m_q [$];
  bit          m_ovf = 1'b0;
  logic [7:0]  m_dout = '0;
  bit          m_dout_known = 1'b1;
  bit          m_prev = 1'b1;
  int          m_clear = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk_sys) begin : model
    int          b;
    int          oldsz;
    int          idx;
    logic [21:0] e;
    bit          act;
    if (reset) begin
      m_q.delete();
      m_ovf        = 1'b0;
      m_dout       = '0;
      m_dout_known = 1'b1;
      m_prev       = 1'b1;
      m_clear      = CLR ? NBYTES : 0;
    end else begin
      act   = !nMREQ && !nWR;
      oldsz = m_q.size();
      if (vram_rd) begin
        idx = int'({vid_page, vram_addr});
        if (m_clear > 0) begin
          m_dout       = '0;
          m_dout_known = 1'b1;
        end else begin
          m_dout       = m_ram[idx];
          m_dout_known = m_known[idx];
        end
      end else if (oldsz > 0 && m_clear == 0) begin
        e              = m_q.pop_front();
        idx            = int'(e[21:8]);
        m_ram[idx]     = e[7:0];
        m_known[idx]   = 1'b1;
      end
      if (act && !m_prev) begin
        b = bank_of(addr, m128, page_ram);
        if (b > 0) begin
          if (oldsz < int'(DEPTH)) m_q.push_back({(b == 7), addr[12:0], din});
          else m_ovf = 1'b1;
        end
      end
      if (m_clear > 0) begin
        m_ram[NBYTES - m_clear]   = 8'h00;
        m_known[NBYTES - m_clear] = 1'b1;
        m_clear--;
      end
      m_prev = act;
    end
  end

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("level", 32'(fifo_level), 32'(m_q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("busy", 32'(busy), 32'(m_clear > 0));
      if (m_dout_known) check("dout", 32'(vram_dout), 32'(m_dout));
    end
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic strobe(input logic [15:0] a, input logic [7:0] d, input int hold);
    addr  = a;
    din   = d;
    nMREQ = 1'b0;
    nWR   = 1'b0;
    repeat (hold) tick();
    nMREQ = 1'b1;
    nWR   = 1'b1;
  endtask

  task automatic rd(input logic pg, input logic [12:0] a);
    vid_page  = pg;
    vram_addr = a;
    vram_rd   = 1'b1;
    tick();
    vram_rd   = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dout", 32'(vram_dout), 32'd0);
    check("rst_busy", 32'(busy), 32'(CLR));
    tick();

`ifdef VRAM_CLEAR_EN
    strobe(16'h4123, 8'h77, 1);
    tick();
    check("clr_queued", 32'(fifo_level), 32'd1);
    n = 3;
    while (busy === 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    check("clr_busy_len", 32'(n), 32'd16384);
    tick();
    check("clr_commit_level", 32'(fifo_level), 32'd0);
    rd(1'b0, 13'h0123);
    check("clr_commit_data", 32'(vram_dout), 32'h77);
    rd(1'b1, 13'h1FFF);
    check("clr_zero", 32'(vram_dout), 32'h00);
`endif

    // Plain bank 5 write then fetch
    m128 = 1'b0;
    strobe(16'h4000, 8'hAA, 1);
    check("t1_push", 32'(fifo_level), 32'd1);
    tick();
    check("t1_pop", 32'(fifo_level), 32'd0);
    rd(1'b0, 13'h0000);
    check("t1_read", 32'(vram_dout), 32'hAA);

    // Paged bank 7 hit, then a non-screen page
    m128 = 1'b1;
    page_ram = 3'd7;
    strobe(16'hC010, 8'h55, 1);
    tick();
    rd(1'b1, 13'h0010);
    check("t2_bank7", 32'(vram_dout), 32'h55);
    page_ram = 3'd3;
    strobe(16'hC020, 8'h66, 1);
    check("t2_nohit", 32'(fifo_level), 32'd0);
    tick();

    // Overflow while reads hold the port
    m128 = 1'b0;
    vid_page = 1'b0;
    vram_addr = 13'h0000;
    vram_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      strobe(16'h4100 + 16'(i), 8'h10 + 8'(i), 1);
      tick();
    end
    check("t3_full", 32'(fifo_level), 32'd4);
    check("t3_overflow", 32'(overflow), 32'd1);
    vram_rd = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      tick();
      check("t3_drain", 32'(fifo_level), 32'(k));
    end
    rd(1'b0, 13'h0100);
    check("t3_first", 32'(vram_dout), 32'h10);
    rd(1'b0, 13'h0103);
    check("t3_fourth", 32'(vram_dout), 32'h13);

    // Long strobe and non-screen addresses
    vram_rd = 1'b1;
    strobe(16'h4200, 8'h21, 10);
    tick();
    check("t4_long", 32'(fifo_level), 32'd1);
    strobe(16'h6000, 8'h22, 1);
    tick();
    strobe(16'h8000, 8'h23, 1);
    tick();
    check("t4_ignored", 32'(fifo_level), 32'd1);
    vram_rd = 1'b0;
    tick();
    check("t4_drain", 32'(fifo_level), 32'd0);
    rd(1'b0, 13'h0200);
    check("t4_data", 32'(vram_dout), 32'h21);

    // Push and pop together at level 2
    vram_rd = 1'b1;
    strobe(16'h4300, 8'h31, 1);
    tick();
    strobe(16'h4301, 8'h32, 1);
    tick();
    check("t5_two", 32'(fifo_level), 32'd2);
    addr = 16'h4302;
    din = 8'h33;
    nMREQ = 1'b0;
    nWR = 1'b0;
    vram_rd = 1'b0;
    tick();
    check("t5_pushpop", 32'(fifo_level), 32'd2);
    nMREQ = 1'b1;
    nWR = 1'b1;
    tick();
    check("t5_pop", 32'(fifo_level), 32'd1);
    tick();

    // Reset with writes queued
    vram_rd = 1'b1;
    vram_addr = 13'h0000;
    for (int i = 0; i < 3; i++) begin
      strobe(16'h4400 + 16'(i), 8'h40 + 8'(i), 1);
      tick();
    end
    check("t6_level3", 32'(fifo_level), 32'd3);
    check("t6_dout", 32'(vram_dout), 32'hAA);
    vram_rd = 1'b0;
    reset = 1'b1;
    tick();
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    check("t6_rst_dout", 32'(vram_dout), 32'd0);
    reset = 1'b0;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] off;
      off = 16'($urandom_range(0, 31));
      reset = (!CLR && $urandom_range(0, 299) == 0);
      nMREQ = ($urandom_range(0, 3) == 0);
      nWR   = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0, 1:    addr = 16'h4000 | off;
        2:       addr = 16'hC000 | off;
        3:       addr = 16'hE000 | off;
        default: addr = 16'($urandom);
      endcase
      din = 8'($urandom);
      m128 = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       page_ram = 3'd5;
        1:       page_ram = 3'd7;
        2:       page_ram = 3'd3;
        default: page_ram = 3'($urandom);
      endcase
      vram_rd = ($urandom_range(0, 4) < 2);
      vid_page = 1'($urandom);
      vram_addr = ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'($urandom_range(0, 31));
      tick();
    end
    reset = 1'b0;
    nMREQ = 1'b1;
    nWR = 1'b1;
    vram_rd = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
